// File: rtl/dm_sba_pkg.sv
// Shared types and helpers for the debug-module system-bus access controller.
//   state_e  : access FSM states
//   sberr_t  : sbcs.sberror codes
//   be_mask  : byte-enable mask for a 2^size byte access at a given byte offset
package dm_sba_pkg;

  typedef enum logic [1:0] {
    Idle,
    Req,
    WaitResp
  } state_e;

  typedef logic [2:0] sberr_t;

  localparam sberr_t SbErrNone    = 3'd0;
  localparam sberr_t SbErrTimeout = 3'd1;
  localparam sberr_t SbErrBus     = 3'd2;
  localparam sberr_t SbErrAlign   = 3'd3;
  localparam sberr_t SbErrSize    = 3'd4;

  // Widest supported bus is 128 bits, i.e. 16 byte lanes.
  localparam int unsigned MaxBeBytes = 16;

  // 2^size ones, shifted to the byte offset of the access. Callers truncate
  // the result to their own lane count.
  function automatic logic [MaxBeBytes-1:0] be_mask(input logic [2:0] size,
                                                    input logic [3:0] offset);
    logic [31:0] ones;
    ones = (32'd1 << (32'd1 << size)) - 32'd1;
    return MaxBeBytes'(ones << offset);
  endfunction

endpackage

// File: rtl/dm_sba_align.sv
// Byte-lane alignment for system-bus accesses (purely combinational).
//   size          : log2 of the access size in bytes
//   offset        : byte offset of the access within the bus word
//   wdata         : write data, LSB-aligned
//   rdata         : raw bus read data
//   be            : byte enables for the addressed lanes
//   wdata_rep     : low 2^size bytes of wdata replicated across every lane
//   rdata_aligned : rdata shifted down to bit 0, bytes above 2^size zeroed
module dm_sba_align
  import dm_sba_pkg::*;
#(
  parameter int unsigned BusWidth = 32
) (
  input  logic [2:0]                      size,
  input  logic [$clog2(BusWidth/8)-1:0]   offset,
  input  logic [BusWidth-1:0]             wdata,
  input  logic [BusWidth-1:0]             rdata,
  output logic [BusWidth/8-1:0]           be,
  output logic [BusWidth-1:0]             wdata_rep,
  output logic [BusWidth-1:0]             rdata_aligned
);

  localparam int unsigned NumBytes = BusWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);

  logic [OffW-1:0]      lane_mask;
  logic [NumBytes-1:0]  keep;
  logic [BusWidth-1:0]  rdata_shifted;

  assign be        = NumBytes'(be_mask(size, 4'(offset)));
  assign keep      = NumBytes'(be_mask(size, 4'd0));
  // Lane i of the bus carries byte (i mod 2^size) of the write data.
  assign lane_mask = OffW'((32'd1 << size) - 32'd1);

  assign rdata_shifted = rdata >> {offset, 3'b000};

  // NOTE: every output of a combinational block gets a default before any
  // conditional logic so no path leaves it unassigned and infers a latch.
  always_comb begin
    wdata_rep     = '0;
    rdata_aligned = '0;
    for (int i = 0; i < NumBytes; i++) begin
      wdata_rep[8*i +: 8]     = wdata[8*(i & int'(lane_mask)) +: 8];
      rdata_aligned[8*i +: 8] = keep[i] ? rdata_shifted[8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/dm_sba_ctrl.sv
// System-bus access controller for the debug module.
// Turns sbcs/sbaddress/sbdata accesses from the DMI register file into single
// transfers on an OBI-style master port, with byte-lane alignment, error
// reporting (timeout, bus, alignment, size), sticky busy-violation flag and
// address autoincrement.
//   clk_i / rst_ni          : clock, asynchronous active-low reset
//   dmactive_i              : synchronous active-low clear of the engine
//   master_*                : bus master port (req/gnt, r_valid/r_err/r_rdata)
//   sbaddress_*, sbdata_*   : DMI register-file strobes and data
//   sbreadonaddr_i, sbreadondata_i, sbautoincrement_i, sbaccess_i : sbcs controls
//   sbbusy_o, sbbusyerror_o, sberror_valid_o/sberror_o : sbcs status
module dm_sba_ctrl
  import dm_sba_pkg::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,

  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,

  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic                  sbaddress_update_o,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  input  logic                  sbbusyerror_clr_i,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);

  localparam int unsigned NumBytes  = BusWidth / 8;
  localparam int unsigned OffW      = $clog2(NumBytes);
  localparam logic [2:0]  MaxSize   = 3'(OffW);
  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam int unsigned CntW      = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast =
      (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  state_e state_q, state_d;

  // Captured access, held stable for the whole bus transfer.
  logic [BusWidth-1:0] addr_q;
  logic [BusWidth-1:0] wdata_q;
  logic [2:0]          size_q;
  logic                we_q;

  logic [CntW-1:0]     cnt_q;

  logic                write_trig, read_trig, trig, accept;
  logic                size_err, align_err, timeout;
  logic [BusWidth-1:0] align_mask;
  logic                start_req, chk_fail, resp_ok, resp_err, tmo;
  sberr_t              chk_code;

  logic [NumBytes-1:0] be;
  logic [BusWidth-1:0] wdata_rep;
  logic [BusWidth-1:0] rdata_aligned;

  // Triggers and the checks applied when one is accepted.
  assign write_trig = sbdata_write_valid_i;
  assign read_trig  = (sbaddress_write_valid_i & sbreadonaddr_i) |
                      (sbdata_read_valid_i & sbreadondata_i);
  assign trig       = write_trig | read_trig;
  assign accept     = trig & (state_q == Idle) & ~sbbusyerror_o;

  assign size_err   = sbaccess_i > MaxSize;
  assign align_mask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
  assign align_err  = |(sbaddress_i & align_mask);
  assign chk_code   = size_err ? SbErrSize : SbErrAlign;

  assign timeout    = TimeoutEn && (cnt_q == CntLast);

  // Next-state logic. A timeout beats a same-cycle grant (the request is
  // abandoned), while a response beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    start_req = 1'b0;
    chk_fail  = 1'b0;
    resp_ok   = 1'b0;
    resp_err  = 1'b0;
    tmo       = 1'b0;
    unique case (state_q)
      Idle: begin
        if (accept) begin
          if (size_err || align_err) begin
            chk_fail = 1'b1;
          end else begin
            start_req = 1'b1;
            state_d   = Req;
          end
        end
      end
      Req: begin
        if (timeout) begin
          tmo     = 1'b1;
          state_d = Idle;
        end else if (master_gnt_i) begin
          state_d = WaitResp;
        end
      end
      WaitResp: begin
        if (master_r_valid_i) begin
          state_d  = Idle;
          resp_err = master_r_err_i;
          resp_ok  = ~master_r_err_i;
        end else if (timeout) begin
          tmo     = 1'b1;
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
    if (!dmactive_i) begin
      state_d = Idle;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= sbaddress_i;
      wdata_q <= sbdata_i;
      size_q  <= sbaccess_i;
      we_q    <= write_trig;
    end
  end

  // Timeout counter: zero on entry to Req, counts every busy cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!dmactive_i || start_req) begin
      cnt_q <= '0;
    end else if (TimeoutEn && (state_q != Idle)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Sticky busy-violation flag; a clear wins over a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbbusyerror_o <= 1'b0;
    end else if (!dmactive_i || sbbusyerror_clr_i) begin
      sbbusyerror_o <= 1'b0;
    end else if (trig && ((state_q != Idle) || sbbusyerror_o)) begin
      sbbusyerror_o <= 1'b1;
    end
  end

  // Completion outputs, registered one cycle after the deciding event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbdata_o           <= '0;
      sbdata_valid_o     <= 1'b0;
      sbaddress_o        <= '0;
      sbaddress_update_o <= 1'b0;
      sberror_valid_o    <= 1'b0;
      sberror_o          <= SbErrNone;
    end else begin
      sbdata_valid_o     <= 1'b0;
      sbaddress_update_o <= 1'b0;
      sberror_valid_o    <= 1'b0;
      if (dmactive_i) begin
        if (chk_fail) begin
          sberror_valid_o <= 1'b1;
          sberror_o       <= chk_code;
        end
        if (tmo) begin
          sberror_valid_o <= 1'b1;
          sberror_o       <= SbErrTimeout;
        end
        if (resp_err) begin
          sberror_valid_o <= 1'b1;
          sberror_o       <= SbErrBus;
        end
        if (resp_ok && !we_q) begin
          sbdata_o       <= rdata_aligned;
          sbdata_valid_o <= 1'b1;
        end
        if (resp_ok && sbautoincrement_i) begin
          sbaddress_o        <= addr_q + (BusWidth'(1) << size_q);
          sbaddress_update_o <= 1'b1;
        end
      end
    end
  end

  dm_sba_align #(
    .BusWidth (BusWidth)
  ) u_align (
    .size          (size_q),
    .offset        (addr_q[OffW-1:0]),
    .wdata         (wdata_q),
    .rdata         (master_r_rdata_i),
    .be            (be),
    .wdata_rep     (wdata_rep),
    .rdata_aligned (rdata_aligned)
  );

  // Bus port is decoded from state and capture registers; quiet outside Req.
  assign sbbusy_o       = (state_q != Idle);
  assign master_req_o   = (state_q == Req);
  assign master_we_o    = master_req_o & we_q;
  assign master_add_o   = master_req_o ? addr_q    : '0;
  assign master_wdata_o = master_req_o ? wdata_rep : '0;
  assign master_be_o    = master_req_o ? be        : '0;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Self-checking bench for dm_sba_ctrl at BusWidth=64, TimeoutCycles=8.
module tb_dm_sba_ctrl;

  localparam int unsigned BW  = 64;
  localparam int unsigned TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          dmactive = 1'b1;
  logic          master_req, master_we, master_gnt, master_r_valid, master_r_err;
  logic [BW-1:0] master_add, master_wdata, master_r_rdata;
  logic [7:0]    master_be;
  logic [BW-1:0] sbaddress_in, sbaddress_out, sbdata_in, sbdata_out;
  logic          sbaddress_write_valid, sbdata_write_valid, sbdata_read_valid;
  logic          sbreadonaddr, sbreadondata, sbautoincrement;
  logic [2:0]    sbaccess, sberror;
  logic          sbdata_valid, sbaddress_update, sbbusy, sbbusyerror;
  logic          sbbusyerror_clr, sberror_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dm_sba_ctrl #(
    .BusWidth      (BW),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .dmactive_i              (dmactive),
    .master_req_o            (master_req),
    .master_add_o            (master_add),
    .master_we_o             (master_we),
    .master_wdata_o          (master_wdata),
    .master_be_o             (master_be),
    .master_gnt_i            (master_gnt),
    .master_r_valid_i        (master_r_valid),
    .master_r_err_i          (master_r_err),
    .master_r_rdata_i        (master_r_rdata),
    .sbaddress_i             (sbaddress_in),
    .sbaddress_write_valid_i (sbaddress_write_valid),
    .sbreadonaddr_i          (sbreadonaddr),
    .sbaddress_o             (sbaddress_out),
    .sbaddress_update_o      (sbaddress_update),
    .sbautoincrement_i       (sbautoincrement),
    .sbaccess_i              (sbaccess),
    .sbreadondata_i          (sbreadondata),
    .sbdata_i                (sbdata_in),
    .sbdata_read_valid_i     (sbdata_read_valid),
    .sbdata_write_valid_i    (sbdata_write_valid),
    .sbdata_o                (sbdata_out),
    .sbdata_valid_o          (sbdata_valid),
    .sbbusy_o                (sbbusy),
    .sbbusyerror_o           (sbbusyerror),
    .sbbusyerror_clr_i       (sbbusyerror_clr),
    .sberror_valid_o         (sberror_valid),
    .sberror_o               (sberror)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic [63:0] exp_next;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_strobes();
    sbaddress_write_valid = 1'b0;
    sbdata_write_valid    = 1'b0;
    sbdata_read_valid     = 1'b0;
  endtask

  task automatic drive_trig(input bit we, input bit via_data, input logic [2:0] size,
                            input logic [63:0] addr, input logic [63:0] wdata);
    sbaccess     = size;
    sbaddress_in = addr;
    sbdata_in    = wdata;
    if (we) sbdata_write_valid = 1'b1;
    else if (via_data) sbdata_read_valid = 1'b1;
    else sbaddress_write_valid = 1'b1;
  endtask

  // Reference model: one random transaction described by its grant delay g
  // and response delay r (cycles after Req entry / WaitResp entry). The
  // timeout budget is TMO busy cycles; a response landing in the last budget
  // cycle still completes, so it succeeds iff g + r <= TMO - 2.
  task automatic run_random(input int idx);
    bit          we, via, autoinc, rerr, chk_fail, timed_out;
    logic [2:0]  size, exp_code;
    logic [63:0] addr, wdata, rdata, mask, exp_be, exp_wd, exp_rd;
    int          n, off, g, r, end_c;
    we      = 1'($urandom_range(0, 1));
    via     = 1'($urandom_range(0, 1));
    autoinc = 1'($urandom_range(0, 1));
    rerr    = ($urandom_range(0, 7) == 0);
    size    = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3))
                                          : 3'($urandom_range(0, 3));
    addr    = {$urandom, $urandom};
    wdata   = {$urandom, $urandom};
    rdata   = {$urandom, $urandom};
    g       = $urandom_range(0, 5);
    r       = $urandom_range(0, 3);
    n = 1; off = 0; mask = '0; exp_be = '0; exp_wd = '0; exp_rd = '0;
    if (size <= 3) begin
      n = 1 << size;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
    end
    chk_fail  = (size > 3) || (addr % n != 0);
    exp_code  = (size > 3) ? 3'd4 : 3'd3;
    timed_out = !chk_fail && (g + r > TMO - 2);
    if (!chk_fail) begin
      off    = int'(addr % 8);
      mask   = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
      exp_be = ((64'd1 << n) - 64'd1) << off;
      for (int k = 0; k < 8 / n; k++) exp_wd |= (wdata & mask) << (8 * n * k);
      exp_rd = (rdata >> (8 * off)) & mask;
    end
    end_c = chk_fail ? 1 : (timed_out ? TMO + 1 : 3 + g + r);

    @(negedge clk_i);
    sbautoincrement = autoinc;
    drive_trig(we, via, size, addr, wdata);
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk_i);
      if (c == 1) clear_strobes();
      if (c == end_c) begin
        check($sformatf("rnd%0d busy", idx), sbbusy, 0);
        check($sformatf("rnd%0d req", idx), master_req, 0);
        if (chk_fail || timed_out || rerr) begin
          check($sformatf("rnd%0d err_valid", idx), sberror_valid, 1);
          check($sformatf("rnd%0d err_code", idx), sberror,
                chk_fail ? exp_code : (timed_out ? 3'd1 : 3'd2));
          check($sformatf("rnd%0d data_valid", idx), sbdata_valid, 0);
          check($sformatf("rnd%0d update", idx), sbaddress_update, 0);
        end else begin
          check($sformatf("rnd%0d err_valid", idx), sberror_valid, 0);
          check($sformatf("rnd%0d data_valid", idx), sbdata_valid, !we);
          if (!we) check($sformatf("rnd%0d rdata", idx), sbdata_out, exp_rd);
          check($sformatf("rnd%0d update", idx), sbaddress_update, autoinc);
          if (autoinc) check($sformatf("rnd%0d next_addr", idx), sbaddress_out, addr + 64'(n));
        end
      end
      master_gnt = !chk_fail && (c == 1 + g);
      if (master_gnt) begin
        check($sformatf("rnd%0d gnt req", idx), master_req, 1);
        check($sformatf("rnd%0d add", idx), master_add, addr);
        check($sformatf("rnd%0d we", idx), master_we, we);
        check($sformatf("rnd%0d be", idx), master_be, exp_be);
        if (we) check($sformatf("rnd%0d wdata", idx), master_wdata, exp_wd);
      end
      master_r_valid = !chk_fail && !timed_out && (c == 2 + g + r);
      master_r_err   = master_r_valid && rerr;
      master_r_rdata = master_r_valid ? rdata : {$urandom, $urandom};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    tbl[0] = '{0, 3'd0, 64'h1003, 64'h0, 64'hAABBCCDD_11223344, 64'h08, 64'h0, 64'h11, 64'h1004};
    tbl[1] = '{1, 3'd1, 64'h2002, 64'hBEEF, 64'h0, 64'h0C, 64'hBEEFBEEF_BEEFBEEF, 64'h0, 64'h2004};
    tbl[2] = '{0, 3'd2, 64'h4004, 64'h0, 64'hAABBCCDD_11223344, 64'hF0, 64'h0, 64'hAABBCCDD, 64'h4008};
    tbl[3] = '{0, 3'd3, 64'h5000, 64'h0, 64'hAABBCCDD_11223344, 64'hFF, 64'h0,
               64'hAABBCCDD_11223344, 64'h5008};
    tbl[4] = '{1, 3'd0, 64'h6007, 64'h345A, 64'h0, 64'h80, 64'h5A5A5A5A_5A5A5A5A, 64'h0, 64'h6008};
    tbl[5] = '{0, 3'd1, 64'h7006, 64'h0, 64'h01234567_89ABCDEF, 64'hC0, 64'h0, 64'h0123, 64'h7008};
    tbl[6] = '{1, 3'd2, 64'h8000, 64'hDEADBEEF_CAFEF00D, 64'h0, 64'h0F, 64'hCAFEF00D_CAFEF00D,
               64'h0, 64'h8004};

    clear_strobes();
    master_gnt = 0; master_r_valid = 0; master_r_err = 0; master_r_rdata = '0;
    sbaddress_in = '0; sbdata_in = '0; sbaccess = '0;
    sbreadonaddr = 1; sbreadondata = 1; sbautoincrement = 1; sbbusyerror_clr = 0;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check("rst req", master_req, 0);
    check("rst busy", sbbusy, 0);
    check("rst busyerror", sbbusyerror, 0);
    check("rst err_valid", sberror_valid, 0);
    check("rst err_code", sberror, 0);
    check("rst data_valid", sbdata_valid, 0);
    check("rst sbdata", sbdata_out, 0);
    check("rst update", sbaddress_update, 0);
    check("rst sbaddress", sbaddress_out, 0);
    check("rst be", master_be, 0);
    rst_ni = 1'b1;

    // Table: minimum-latency transfers (gnt at T+1, r_valid at T+2).
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      drive_trig(tbl[i].we, 1'b0, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      @(negedge clk_i);
      clear_strobes();
      check($sformatf("vec%0d req", i), master_req, 1);
      check($sformatf("vec%0d add", i), master_add, tbl[i].addr);
      check($sformatf("vec%0d we", i), master_we, tbl[i].we);
      check($sformatf("vec%0d be", i), master_be, tbl[i].exp_be);
      if (tbl[i].we) check($sformatf("vec%0d wdata", i), master_wdata, tbl[i].exp_wdata);
      master_gnt = 1;
      @(negedge clk_i);
      master_gnt = 0;
      check($sformatf("vec%0d busy", i), sbbusy, 1);
      check($sformatf("vec%0d req low", i), master_req, 0);
      master_r_valid = 1; master_r_rdata = tbl[i].rdata;
      @(negedge clk_i);
      master_r_valid = 0;
      check($sformatf("vec%0d busy done", i), sbbusy, 0);
      check($sformatf("vec%0d data_valid", i), sbdata_valid, !tbl[i].we);
      if (!tbl[i].we) check($sformatf("vec%0d sbdata", i), sbdata_out, tbl[i].exp_rdata);
      check($sformatf("vec%0d update", i), sbaddress_update, 1);
      check($sformatf("vec%0d next_addr", i), sbaddress_out, tbl[i].exp_next);
      check($sformatf("vec%0d err_valid", i), sberror_valid, 0);
    end

    // Size error, then alignment error: no request, error at T+1.
    @(negedge clk_i);
    drive_trig(1'b1, 1'b0, 3'd4, 64'h3000, 64'h1);
    @(negedge clk_i);
    clear_strobes();
    check("size req", master_req, 0);
    check("size busy", sbbusy, 0);
    check("size err_valid", sberror_valid, 1);
    check("size err_code", sberror, 4);
    drive_trig(1'b0, 1'b0, 3'd2, 64'h3001, 64'h0);
    @(negedge clk_i);
    clear_strobes();
    check("align req", master_req, 0);
    check("align busy", sbbusy, 0);
    check("align err_valid", sberror_valid, 1);
    check("align err_code", sberror, 3);
    @(negedge clk_i);
    check("align pulse end", sberror_valid, 0);

    // Busy violation in WaitResp, drop while sticky, clear beats set.
    drive_trig(1'b1, 1'b0, 3'd2, 64'h100, 64'h11);
    @(negedge clk_i);
    clear_strobes();
    master_gnt = 1;
    @(negedge clk_i);
    master_gnt = 0;
    sbdata_write_valid = 1;
    @(negedge clk_i);
    sbdata_write_valid = 0;
    check("busyerr set", sbbusyerror, 1);
    check("busyerr still busy", sbbusy, 1);
    master_r_valid = 1;
    @(negedge clk_i);
    master_r_valid = 0;
    check("busyerr idle", sbbusy, 0);
    check("busyerr sticky", sbbusyerror, 1);
    drive_trig(1'b1, 1'b0, 3'd2, 64'h104, 64'h22);
    @(negedge clk_i);
    clear_strobes();
    check("busyerr drop req", master_req, 0);
    check("busyerr held", sbbusyerror, 1);
    drive_trig(1'b1, 1'b0, 3'd2, 64'h104, 64'h22);
    sbbusyerror_clr = 1;
    @(negedge clk_i);
    clear_strobes();
    sbbusyerror_clr = 0;
    check("busyerr clr wins", sbbusyerror, 0);
    check("busyerr clr drop req", master_req, 0);
    drive_trig(1'b1, 1'b0, 3'd2, 64'h108, 64'h33);
    @(negedge clk_i);
    clear_strobes();
    check("busyerr after clr req", master_req, 1);
    check("busyerr after clr add", master_add, 64'h108);
    master_gnt = 1;
    @(negedge clk_i);
    master_gnt = 0;
    master_r_valid = 1;
    @(negedge clk_i);
    master_r_valid = 0;
    check("busyerr after clr done", sbbusy, 0);

    // Timeout with no grant; a late response in Idle is ignored.
    drive_trig(1'b0, 1'b0, 3'd2, 64'h400, 64'h0);
    hi = 0;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk_i);
      if (c == 1) clear_strobes();
      if (master_req) hi++;
    end
    check("tmo req cycles", 64'(hi), 64'(TMO));
    @(negedge clk_i);
    check("tmo req low", master_req, 0);
    check("tmo busy", sbbusy, 0);
    check("tmo err_valid", sberror_valid, 1);
    check("tmo err_code", sberror, 1);
    master_r_valid = 1; master_r_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk_i);
    master_r_valid = 0;
    check("late rvalid data_valid", sbdata_valid, 0);
    check("late rvalid err_valid", sberror_valid, 0);
    check("late rvalid busy", sbbusy, 0);

    // Bus error on read completion.
    sbautoincrement = 1;
    drive_trig(1'b0, 1'b1, 3'd2, 64'h40, 64'h0);
    @(negedge clk_i);
    clear_strobes();
    master_gnt = 1;
    @(negedge clk_i);
    master_gnt = 0;
    master_r_valid = 1; master_r_err = 1; master_r_rdata = 64'h1234;
    @(negedge clk_i);
    master_r_valid = 0; master_r_err = 0;
    check("buserr err_valid", sberror_valid, 1);
    check("buserr err_code", sberror, 2);
    check("buserr data_valid", sbdata_valid, 0);
    check("buserr update", sbaddress_update, 0);

    // dmactive low while in Req abandons the request.
    drive_trig(1'b1, 1'b0, 3'd3, 64'h200, 64'h55);
    @(negedge clk_i);
    clear_strobes();
    check("dmactive req before", master_req, 1);
    dmactive = 0;
    @(negedge clk_i);
    dmactive = 1;
    check("dmactive req after", master_req, 0);
    check("dmactive busy after", sbbusy, 0);
    @(negedge clk_i);
    check("dmactive stays idle", sbbusy, 0);
    check("dmactive no error", sberror_valid, 0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 200; i++) run_random(i);

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_sba_ctrl.md
# dm_sba_ctrl

Parametrised system-bus access controller for the debug module, replacing the fixed 32/64-bit access engine. It sits between the DMI register file (sbcs/sbaddress/sbdata) and a single OBI-style bus master port. It supports bus widths 32–128 with byte-lane alignment of read and write data, and reports bus, size, alignment and timeout errors with their sbcs error codes. It detects busy-violations (sticky sbbusyerror) and autoincrements the address after each successful access.

## Interface
- BusWidth, 32: bus data/address width; legal values 32, 64, 128.
- TimeoutCycles, 1024: cycles from request assertion to abort; 0 disables the timeout.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- dmactive_i  in  1  synchronous clear, active-low
- master_req_o / master_we_o  out  1  bus request / write enable
- master_add_o / master_wdata_o  out  BusWidth  bus address / write data
- master_be_o  out  BusWidth/8  byte enables
- master_gnt_i / master_r_valid_i / master_r_err_i  in  1  grant / response valid / response error
- master_r_rdata_i  in  BusWidth  read data
- sbaddress_i  in  BusWidth  current sbaddress
- sbaddress_write_valid_i, sbdata_write_valid_i, sbdata_read_valid_i  in  1  DMI access strobes
- sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  in  1  sbcs control bits
- sbaccess_i  in  3  log2 access size in bytes
- sbdata_i  in  BusWidth  write data
- sbdata_o  out  BusWidth  read data, LSB-aligned
- sbdata_valid_o  out  1  read data valid, 1-cycle pulse
- sbaddress_o / sbaddress_update_o  out  BusWidth / 1  incremented address + 1-cycle load pulse
- sbbusy_o  out  1  access in progress
- sbbusyerror_o  out  1  sticky busy-violation flag; sbbusyerror_clr_i  in  1  clears it
- sberror_valid_o  out  1  1-cycle error pulse; sberror_o  out  3  error code

## Operation
- States: Idle, Req, WaitResp (package enum). sbbusy_o = (state != Idle).
- Triggers, evaluated only in Idle with sbbusyerror_o low:
  - write: sbdata_write_valid_i.
  - read: (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i).
  - Priority when simultaneous: write over read.
- On a trigger, capture addr=sbaddress_i, size=sbaccess_i, we and wdata=sbdata_i.
- Checks at trigger; on failure, no bus request is issued, state stays Idle, sberror pulses next cycle:
  - size > log2(BusWidth/8) → sberror 4.
  - addr not aligned to size → sberror 3.
- Any trigger while state != Idle, or while sbbusyerror_o is high:
  - sets sbbusyerror_o; the trigger is dropped.
  - sbbusyerror_clr_i clears the flag; the clear wins over a same-cycle set.
- Req: master_req_o held high with stable add/we/wdata/be until master_gnt_i; then → WaitResp.
- WaitResp: on master_r_valid_i → Idle.
  - master_r_err_i=1 → sberror 2, no data, no increment.
  - Else, reads → sbdata_o = rdata >> (8·addr offset), bits above 8·2^size zeroed; sbdata_valid_o pulses (writes: no pulse).
  - Else, with sbautoincrement_i → sbaddress_o = addr + 2^size (mod 2^BusWidth), sbaddress_update_o pulses.
- master_wdata_o: low 2^size bytes of wdata replicated across all lanes.
- master_be_o: 2^size ones shifted left by addr offset.
- master_add_o: full captured address, not truncated.
- Timeout:
  - Counter clears on entry to Req and counts in Req and WaitResp.
  - At TimeoutCycles → sberror 1, master_req_o drops, → Idle.
  - A late response arriving in Idle is ignored.
- master_r_valid_i is honoured only in WaitResp.
- dmactive_i low: next cycle state Idle; sbbusyerror_o, counter and all pulses cleared; an outstanding request is abandoned.
- Reset values: all outputs 0, state Idle.

## Timing
- Trigger at cycle T → master_req_o high at T+1.
- Grant at cycle G → WaitResp at G+1.
- r_valid at cycle R → sbdata_valid_o / sberror_valid_o / sbaddress_update_o at R+1; sbbusy_o low at R+1.
- Minimum access latency, trigger to data: 3 cycles, with gnt at T+1 and r_valid at T+2.
- Check error: trigger at T → sberror_valid_o at T+1; sbbusy_o never high.
- A new trigger is accepted in the same cycle as the completion pulse.
- All outputs are registered except the master_* signals, which are decoded from registered state and the capture registers.

## Structure
- Package dm_sba_pkg: state_e; sberror codes SbErrNone=0, SbErrTimeout=1, SbErrBus=2, SbErrAlign=3, SbErrSize=4; function for the be mask.
- Sub-module dm_sba_align (combinational, BusWidth-parametrised): be generation, write-lane replication, read right-shift and zero-mask.
- Only the FSM, capture registers, timeout counter and sticky flag live at top level.

## Test plan
- BusWidth=64, sbaccess=0, addr 0x1003, read, rdata 0xAABBCCDD_11223344 → be 0x08, sbdata_o 0x11, sbdata_valid_o at R+1.
- BusWidth=32, sbaccess=1, write sbdata 0xBEEF, addr 0x2002, autoinc → wdata 0xBEEFBEEF, be 0xC, sbaddress_o 0x2004 with update pulse.
- sbaccess=2 at addr 0x3001 → no master_req_o, sberror 3 at T+1; BusWidth=32 with sbaccess=3 → sberror 4.
- Write trigger while in WaitResp → sbbusyerror_o=1 and stays 1; following trigger in Idle ignored until sbbusyerror_clr_i.
- TimeoutCycles=8, gnt never asserted → master_req_o high for 8 cycles, then sberror 1, Idle; late r_valid ignored.
- master_r_err_i on read completion → sberror 2, no sbdata_valid_o, no address update; dmactive_i low mid-Req → Idle next cycle, req low.
